// File: rtl/mr_wb.sv
// mr_wb: writeback/retire stage.
// Takes one writeback bundle per cycle from the load/store stage. It writes the
// integer register file and resolves branch mispredictions into a front-end
// redirect. Wrong-path instructions are squashed by comparing the epoch bit of
// their instruction ID with the current epoch. The stage also keeps retire and
// mispredict counters and a sticky flag for out-of-order retirement.
module mr_wb #(
    parameter int XLEN        = 32,
    parameter int REGSEL_BITS = 5,
    parameter int INSTID_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_write_i,
    input  logic [INSTID_BITS-1:0] wb_instid_i,
    input  logic [XLEN-1:0]        wb_data_i,
    input  logic [REGSEL_BITS-1:0] wb_dst_reg_i,
    input  logic [XLEN-1:0]        wb_payload_i,
    input  logic [1:0]             wb_payload_kind_i,
    input  logic                   wb_is_jump_i,
    input  logic                   wb_jump_taken_i,
    input  logic                   wb_jump_predicted_i,
    output logic                   rf_we_o,
    output logic [REGSEL_BITS-1:0] rf_waddr_o,
    output logic [XLEN-1:0]        rf_wdata_o,
    output logic                   redirect_o,
    output logic [XLEN-1:0]        redirect_pc_o,
    output logic                   epoch_o,
    output logic                   retire_o,
    output logic [63:0]            minstret_o,
    output logic [31:0]            mispredict_cnt_o,
    output logic                   seq_err_o
);

    localparam int SEQ_W = INSTID_BITS - 1;
    localparam logic [SEQ_W-1:0] SEQ_ZERO = {SEQ_W{1'b0}};
    localparam logic [SEQ_W-1:0] SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] KIND_NONE    = 2'd0;
    localparam logic [1:0] KIND_LINK    = 2'd1;
    localparam logic [1:0] KIND_NOWRITE = 2'd2;

    // Combinational decode of the incoming bundle.
    logic                   accept_s;
    logic                   writes_kind_s;
    logic [XLEN-1:0]        wdata_sel_s;
    logic                   rf_we_s;
    logic                   mispred_s;
    logic [XLEN-1:0]        redirect_pc_s;
    logic                   seq_bad_s;
    logic [SEQ_W-1:0]       exp_seq_nxt_s;

    // State and registered outputs.
    logic                   rf_we_r;
    logic [REGSEL_BITS-1:0] rf_waddr_r;
    logic [XLEN-1:0]        rf_wdata_r;
    logic                   redirect_r;
    logic [XLEN-1:0]        redirect_pc_r;
    logic                   epoch_r;
    logic                   retire_r;
    logic [63:0]            minstret_r;
    logic [31:0]            mispredict_cnt_r;
    logic                   seq_err_r;
    logic [SEQ_W-1:0]       exp_seq_r;

    // Decode accept, register-file write, mispredict and sequence check for this cycle.
    always_comb begin
        accept_s      = 1'b0;
        writes_kind_s = 1'b0;
        wdata_sel_s   = wb_data_i;
        rf_we_s       = 1'b0;
        mispred_s     = 1'b0;
        redirect_pc_s = wb_payload_i;
        seq_bad_s     = 1'b0;
        exp_seq_nxt_s = exp_seq_r;

        // Only current-epoch instructions are on the correct path.
        if (wb_write_i && (wb_instid_i[INSTID_BITS-1] == epoch_r)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end

        case (wb_payload_kind_i)
            KIND_NONE: begin
                writes_kind_s = 1'b1;
                wdata_sel_s   = wb_data_i;
            end
            KIND_LINK: begin
                writes_kind_s = 1'b1;
                wdata_sel_s   = wb_payload_i;
            end
            KIND_NOWRITE: begin
                writes_kind_s = 1'b0;
                wdata_sel_s   = wb_data_i;
            end
            default: begin
                // The reserved kind retires without touching the register file.
                writes_kind_s = 1'b0;
                wdata_sel_s   = wb_data_i;
            end
        endcase

        // x0 is hardwired to zero, so writes to it are dropped.
        rf_we_s = accept_s && writes_kind_s && (wb_dst_reg_i != {REGSEL_BITS{1'b0}});

        mispred_s = accept_s && wb_is_jump_i && (wb_jump_taken_i != wb_jump_predicted_i);

        // Refetch from the resolved target if taken, else from the fall-through PC.
        if (wb_jump_taken_i) begin
            redirect_pc_s = wb_data_i;
        end else begin
            redirect_pc_s = wb_payload_i;
        end

        // Fetch restarts numbering at zero after a redirect. For this reason the
        // mispredicting instruction is not sequence-checked. It resets the
        // expected number instead.
        if (mispred_s) begin
            seq_bad_s     = 1'b0;
            exp_seq_nxt_s = SEQ_ZERO;
        end else if (accept_s) begin
            seq_bad_s     = (wb_instid_i[SEQ_W-1:0] != exp_seq_r);
            exp_seq_nxt_s = exp_seq_r + SEQ_ONE;
        end else begin
            seq_bad_s     = 1'b0;
            exp_seq_nxt_s = exp_seq_r;
        end
    end

    // Register the outputs and update the epoch, the counters and the sequence tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_r          <= 1'b0;
            rf_waddr_r       <= {REGSEL_BITS{1'b0}};
            rf_wdata_r       <= {XLEN{1'b0}};
            redirect_r       <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
            epoch_r          <= 1'b0;
            retire_r         <= 1'b0;
            minstret_r       <= 64'd0;
            mispredict_cnt_r <= 32'd0;
            seq_err_r        <= 1'b0;
            exp_seq_r        <= SEQ_ZERO;
        end else begin
            rf_we_r    <= rf_we_s;
            retire_r   <= accept_s;
            redirect_r <= mispred_s;
            exp_seq_r  <= exp_seq_nxt_s;

            // Address and data hold their last written values between strobes.
            if (rf_we_s) begin
                rf_waddr_r <= wb_dst_reg_i;
                rf_wdata_r <= wdata_sel_s;
            end

            if (mispred_s) begin
                redirect_pc_r    <= redirect_pc_s;
                epoch_r          <= ~epoch_r;
                mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
            end

            if (accept_s) begin
                minstret_r <= minstret_r + 64'd1;
            end

            if (seq_bad_s) begin
                seq_err_r <= 1'b1;
            end
        end
    end

    assign rf_we_o          = rf_we_r;
    assign rf_waddr_o       = rf_waddr_r;
    assign rf_wdata_o       = rf_wdata_r;
    assign redirect_o       = redirect_r;
    assign redirect_pc_o    = redirect_pc_r;
    assign epoch_o          = epoch_r;
    assign retire_o         = retire_r;
    assign minstret_o       = minstret_r;
    assign mispredict_cnt_o = mispredict_cnt_r;
    assign seq_err_o        = seq_err_r;

endmodule

// File: tb/tb_mr_wb.sv
// Testbench for mr_wb. It runs directed scenarios from the feature list and
// then a randomized stream. Expected values come from a behavioural model of
// the retire rules.
module tb_mr_wb;

    logic        clk;
    logic        rst;
    logic        wb_write_i;
    logic [3:0]  wb_instid_i;
    logic [31:0] wb_data_i;
    logic [4:0]  wb_dst_reg_i;
    logic [31:0] wb_payload_i;
    logic [1:0]  wb_payload_kind_i;
    logic        wb_is_jump_i;
    logic        wb_jump_taken_i;
    logic        wb_jump_predicted_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        epoch_o;
    logic        retire_o;
    logic [63:0] minstret_o;
    logic [31:0] mispredict_cnt_o;
    logic        seq_err_o;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic        m_we, m_redir, m_ret, m_epoch, m_err;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_rpc, m_mis;
    logic [63:0] m_minstret;
    int          m_seq;

    mr_wb dut (
        .clk(clk), .rst(rst),
        .wb_write_i(wb_write_i), .wb_instid_i(wb_instid_i), .wb_data_i(wb_data_i),
        .wb_dst_reg_i(wb_dst_reg_i), .wb_payload_i(wb_payload_i),
        .wb_payload_kind_i(wb_payload_kind_i), .wb_is_jump_i(wb_is_jump_i),
        .wb_jump_taken_i(wb_jump_taken_i), .wb_jump_predicted_i(wb_jump_predicted_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .epoch_o(epoch_o),
        .retire_o(retire_o), .minstret_o(minstret_o),
        .mispredict_cnt_o(mispredict_cnt_o), .seq_err_o(seq_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_we = 1'b0; m_redir = 1'b0; m_ret = 1'b0; m_epoch = 1'b0; m_err = 1'b0;
        m_waddr = 5'd0; m_wdata = 32'd0; m_rpc = 32'd0; m_mis = 32'd0;
        m_minstret = 64'd0; m_seq = 0;
    endtask

    // Update the model with the retire rules for one bundle.
    task automatic model_step(input logic w, input logic [3:0] id, input logic [31:0] data,
                              input logic [4:0] dst, input logic [31:0] pay, input logic [1:0] kind,
                              input logic j, input logic t, input logic p);
        m_we = 1'b0; m_ret = 1'b0; m_redir = 1'b0;
        if (w && (id[3] == m_epoch)) begin
            m_ret = 1'b1;
            m_minstret = m_minstret + 64'd1;
            if ((kind == 2'd0 || kind == 2'd1) && dst != 5'd0) begin
                m_we = 1'b1;
                m_waddr = dst;
                m_wdata = (kind == 2'd1) ? pay : data;
            end
            if (j && (t != p)) begin
                m_redir = 1'b1;
                m_rpc = t ? data : pay;
                m_epoch = ~m_epoch;
                m_mis = m_mis + 32'd1;
                m_seq = 0;
            end else begin
                if (int'(id[2:0]) != m_seq) m_err = 1'b1;
                m_seq = (m_seq + 1) % 8;
            end
        end
    endtask

    // Drive one bundle and update the model. Return 1 ns after the capturing edge.
    task automatic apply(input logic w, input logic [3:0] id, input logic [31:0] data,
                         input logic [4:0] dst, input logic [31:0] pay, input logic [1:0] kind,
                         input logic j, input logic t, input logic p);
        wb_write_i = w; wb_instid_i = id; wb_data_i = data; wb_dst_reg_i = dst;
        wb_payload_i = pay; wb_payload_kind_i = kind; wb_is_jump_i = j;
        wb_jump_taken_i = t; wb_jump_predicted_i = p;
        model_step(w, id, data, dst, pay, kind, j, t, p);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        total++; if ({rf_we_o, retire_o, redirect_o, epoch_o, seq_err_o} !== 5'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=0", {rf_we_o, retire_o, redirect_o, epoch_o, seq_err_o}); end
        total++; if (minstret_o !== 64'd0 || mispredict_cnt_o !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0h/%0h exp=0/0", minstret_o, mispredict_cnt_o); end
        total++; if (rf_waddr_o !== 5'd0 || rf_wdata_o !== 32'd0 || redirect_pc_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h/%0h/%0h exp=0", rf_waddr_o, rf_wdata_o, redirect_pc_o); end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        apply(1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        total++; if (retire_o !== 1'b0 || minstret_o !== 64'd0) begin bad++; $display("FAIL reset_release got=%b/%0d exp=0/0", retire_o, minstret_o); end
    endtask

    task automatic test_alu();
        apply(1'b1, 4'h0, 32'h1234, 5'd5, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h1234) begin bad++; $display("FAIL alu_write got=%b/%0d/%0h exp=1/5/1234", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (retire_o !== 1'b1 || minstret_o !== 64'd1) begin bad++; $display("FAIL alu_retire got=%b/%0d exp=1/1", retire_o, minstret_o); end
    endtask

    task automatic test_jal_mispredict();
        apply(1'b1, 4'h1, 32'h200, 5'd1, 32'h104, 2'd1, 1'b1, 1'b1, 1'b0);
        total++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd1 || rf_wdata_o !== 32'h104) begin bad++; $display("FAIL jal_link got=%b/%0d/%0h exp=1/1/104", rf_we_o, rf_waddr_o, rf_wdata_o); end
        total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200) begin bad++; $display("FAIL jal_redirect got=%b/%0h exp=1/200", redirect_o, redirect_pc_o); end
        total++; if (epoch_o !== 1'b1 || mispredict_cnt_o !== 32'd1) begin bad++; $display("FAIL jal_epoch got=%b/%0d exp=1/1", epoch_o, mispredict_cnt_o); end
    endtask

    task automatic test_squash();
        apply(1'b1, 4'h2, 32'h55, 5'd6, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        total++; if (rf_we_o !== 1'b0 || retire_o !== 1'b0 || redirect_o !== 1'b0) begin bad++; $display("FAIL squash_id2 got=%b/%b/%b exp=0/0/0", rf_we_o, retire_o, redirect_o); end
        apply(1'b1, 4'h3, 32'h66, 5'd7, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        total++; if (rf_we_o !== 1'b0 || retire_o !== 1'b0 || minstret_o !== 64'd2) begin bad++; $display("FAIL squash_id3 got=%b/%b/%0d exp=0/0/2", rf_we_o, retire_o, minstret_o); end
        apply(1'b1, 4'h8, 32'h77, 5'd8, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        total++; if (retire_o !== 1'b1 || rf_wdata_o !== 32'h77 || seq_err_o !== 1'b0) begin bad++; $display("FAIL new_epoch_accept got=%b/%0h/%b exp=1/77/0", retire_o, rf_wdata_o, seq_err_o); end
    endtask

    task automatic test_branch();
        apply(1'b1, 4'h9, 32'h800, 5'd0, 32'h44, 2'd2, 1'b1, 1'b0, 1'b1);
        total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h44 || epoch_o !== 1'b0) begin bad++; $display("FAIL nt_branch got=%b/%0h/%b exp=1/44/0", redirect_o, redirect_pc_o, epoch_o); end
        apply(1'b1, 4'h0, 32'h900, 5'd0, 32'h50, 2'd2, 1'b1, 1'b1, 1'b1);
        total++; if (redirect_o !== 1'b0 || retire_o !== 1'b1 || mispredict_cnt_o !== 32'd2) begin bad++; $display("FAIL good_branch got=%b/%b/%0d exp=0/1/2", redirect_o, retire_o, mispredict_cnt_o); end
        apply(1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        total++; if (retire_o !== 1'b0 || rf_we_o !== 1'b0 || redirect_pc_o !== 32'h44 || rf_wdata_o !== 32'h77) begin bad++; $display("FAIL idle_hold got=%b/%b/%0h/%0h exp=0/0/44/77", retire_o, rf_we_o, redirect_pc_o, rf_wdata_o); end
    endtask

    task automatic test_x0_and_seq();
        logic [3:0] id;
        apply(1'b1, 4'h1, 32'hFFFF, 5'd0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        total++; if (rf_we_o !== 1'b0 || retire_o !== 1'b1 || seq_err_o !== 1'b0) begin bad++; $display("FAIL x0_write got=%b/%b/%b exp=0/1/0", rf_we_o, retire_o, seq_err_o); end
        // Sequence numbers 2..7 and then 0,1 wrap naturally without an error.
        for (int s = 2; s < 10; s++) begin
            id = 4'(s % 8);
            apply(1'b1, id, 32'(s), 5'd3, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        end
        total++; if (seq_err_o !== 1'b0 || minstret_o !== m_minstret) begin bad++; $display("FAIL seq_wrap got=%b/%0d exp=0/%0d", seq_err_o, minstret_o, m_minstret); end
        apply(1'b1, 4'h3, 32'h3, 5'd3, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        total++; if (seq_err_o !== 1'b1) begin bad++; $display("FAIL seq_gap got=%b exp=1", seq_err_o); end
        apply(1'b1, 4'h4, 32'h4, 5'd3, 32'h0, 2'd3, 1'b0, 1'b0, 1'b0);
        total++; if (seq_err_o !== 1'b1 || rf_we_o !== 1'b0 || retire_o !== 1'b1) begin bad++; $display("FAIL seq_sticky_kind3 got=%b/%b/%b exp=1/0/1", seq_err_o, rf_we_o, retire_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mis0;
        logic [3:0]  id;
        mis0 = m_mis;
        id = {m_epoch, 3'(m_seq)};
        apply(1'b1, id, 32'hA00, 5'd0, 32'hB00, 2'd2, 1'b1, 1'b1, 1'b0);
        total++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'hA00) begin bad++; $display("FAIL b2b_first got=%b/%0h exp=1/a00", redirect_o, redirect_pc_o); end
        id = {~m_epoch, 3'd1};
        apply(1'b1, id, 32'hC00, 5'd0, 32'hD00, 2'd2, 1'b1, 1'b1, 1'b0);
        total++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'hA00 || mispredict_cnt_o !== mis0 + 32'd1) begin bad++; $display("FAIL b2b_second got=%b/%0h/%0d exp=0/a00/%0d", redirect_o, redirect_pc_o, mispredict_cnt_o, mis0 + 32'd1); end
    endtask

    task automatic test_async_reset();
        wb_write_i = 1'b1; wb_instid_i = {m_epoch, 3'(m_seq)}; wb_data_i = 32'h1;
        wb_dst_reg_i = 5'd9; wb_payload_kind_i = 2'd0; wb_is_jump_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if ({rf_we_o, retire_o, redirect_o, epoch_o, seq_err_o} !== 5'b0 || minstret_o !== 64'd0 || mispredict_cnt_o !== 32'd0) begin bad++; $display("FAIL async_reset got=%b/%0d/%0d exp=0/0/0", {rf_we_o, retire_o, redirect_o, epoch_o, seq_err_o}, minstret_o, mispredict_cnt_o); end
        @(posedge clk); #1;
        total++; if (retire_o !== 1'b0 || rf_wdata_o !== 32'd0 || redirect_pc_o !== 32'd0) begin bad++; $display("FAIL reset_held got=%b/%0h/%0h exp=0/0/0", retire_o, rf_wdata_o, redirect_pc_o); end
        wb_write_i = 1'b0;
        rst = 1'b1;
        model_reset();
        apply(1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic w, ep, j, t, p;
        logic [2:0] sq;
        logic [1:0] kind;
        for (int i = 0; i < 400; i++) begin
            w    = ($urandom_range(0, 9) < 8);
            ep   = ($urandom_range(0, 9) < 8) ? m_epoch : ~m_epoch;
            j    = ($urandom_range(0, 3) == 0);
            t    = 1'($urandom_range(0, 1));
            p    = 1'($urandom_range(0, 1));
            kind = 2'($urandom_range(0, 3));
            sq   = 3'(m_seq);
            if (!j && $urandom_range(0, 59) == 0) sq = 3'($urandom_range(0, 7));
            apply(w, {ep, sq}, $urandom, 5'($urandom_range(0, 31)), $urandom, kind, j, t, p);
            total++; if (rf_we_o !== m_we || retire_o !== m_ret || redirect_o !== m_redir) begin bad++; $display("FAIL rnd_pulses[%0d] got=%b%b%b exp=%b%b%b", i, rf_we_o, retire_o, redirect_o, m_we, m_ret, m_redir); end
            total++; if (rf_waddr_o !== m_waddr || rf_wdata_o !== m_wdata || redirect_pc_o !== m_rpc) begin bad++; $display("FAIL rnd_data[%0d] got=%0h/%0h/%0h exp=%0h/%0h/%0h", i, rf_waddr_o, rf_wdata_o, redirect_pc_o, m_waddr, m_wdata, m_rpc); end
            total++; if (epoch_o !== m_epoch || minstret_o !== m_minstret || mispredict_cnt_o !== m_mis || seq_err_o !== m_err) begin bad++; $display("FAIL rnd_state[%0d] got=%b/%0d/%0d/%b exp=%b/%0d/%0d/%b", i, epoch_o, minstret_o, mispredict_cnt_o, seq_err_o, m_epoch, m_minstret, m_mis, m_err); end
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_write_i = 1'b0; wb_instid_i = 4'h0; wb_data_i = 32'h0; wb_dst_reg_i = 5'd0;
        wb_payload_i = 32'h0; wb_payload_kind_i = 2'd0; wb_is_jump_i = 1'b0;
        wb_jump_taken_i = 1'b0; wb_jump_predicted_i = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_alu();
        test_jal_mispredict();
        test_squash();
        test_branch();
        test_x0_and_seq();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mr_wb.md
Name: mr_wb

Overview:
Writeback/retire stage directly downstream of the load/store stage. Consumes the registered writeback bundle (one instruction per cycle, no stall), writes the integer register file, detects branch mispredictions and issues a front-end redirect, and discards wrong-path instructions using an epoch bit in the instruction ID. Maintains retire and mispredict counters for the CSR unit and flags in-order retirement violations.

Parameters:
XLEN, 32, data/address width
REGSEL_BITS, 5, register selector width
INSTID_BITS, 4, instruction ID width; MSB = epoch, [INSTID_BITS-2:0] = sequence number

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
wb_write_i  in  1  valid instruction from load/store stage this cycle
wb_instid_i  in  INSTID_BITS  instruction ID {epoch, seq}
wb_data_i  in  XLEN  result (load data / ALU result / jump target)
wb_dst_reg_i  in  REGSEL_BITS  destination register
wb_payload_i  in  XLEN  secondary value (link address = PC+4 for jumps)
wb_payload_kind_i  in  2  0=NONE (rd<=data), 1=LINK (rd<=payload), 2=NOWRITE, 3=reserved
wb_is_jump_i  in  1  control-transfer instruction
wb_jump_taken_i  in  1  resolved direction
wb_jump_predicted_i  in  1  predicted direction
rf_we_o  out  1  register file write enable
rf_waddr_o  out  REGSEL_BITS  write address
rf_wdata_o  out  XLEN  write data
redirect_o  out  1  one-cycle pulse: flush front end, refetch
redirect_pc_o  out  XLEN  refetch address
epoch_o  out  1  current epoch; fetch tags new instructions with it
retire_o  out  1  one-cycle pulse per retired instruction
minstret_o  out  64  retired-instruction count
mispredict_cnt_o  out  32  mispredict count
seq_err_o  out  1  sticky out-of-order retirement flag

Behaviour:
- Reset (rst=0, async): all outputs 0, epoch=0, expected seq=0, counters 0, seq_err_o=0. Deassertion is applied at the next clock edge; no retirement occurs in the deassertion cycle.
- Accept condition: wb_write_i=1 and wb_instid_i MSB == epoch. Inputs that fail this condition are squashed: no RF write, no retire, no counter or sequence update.
- All outputs are registered; latency is 1 cycle from accepted input to rf_we_o/retire_o/redirect_o.
- RF write: rf_we_o=1 when accepted, kind is NONE or LINK, and dst != 0. Data is wb_data_i for NONE and wb_payload_i for LINK. Writes to x0 are dropped but still retire.
- Mispredict: accepted, is_jump=1, and taken != predicted. In that case:
  - redirect_o=1.
  - redirect_pc_o = taken ? wb_data_i : wb_payload_i.
  - epoch toggles at the same edge, so the next cycle's inputs with the old epoch are squashed.
  - mispredict_cnt_o increments.
  - expected seq becomes 0, because fetch restarts numbering at 0 in the new epoch.
- The mispredicting jump itself still retires and writes its link register.
- Sequence check: on accept, if seq != expected then seq_err_o <= 1 (sticky until reset); the check is not applied in the redirect cycle. Expected seq increments modulo 2^(INSTID_BITS-1), with natural wrap from 7 to 0 at the default width.
- minstret_o increments by 1 per accept and wraps at 2^64. mispredict_cnt_o wraps at 2^32.
- redirect_o, retire_o, and rf_we_o are single-cycle pulses and are 0 on idle cycles. rf_waddr_o, rf_wdata_o, and redirect_pc_o hold their last values when not strobed.
- Back-to-back mispredicts: the second jump carries the old epoch and is squashed, so only one redirect is issued.
- payload_kind=3: the instruction retires with no RF write.

Test Plan:
- Reset, then ALU op id=0x0, dst=5, data=0x1234, kind NONE -> next cycle rf_we_o=1, waddr=5, wdata=0x1234, retire_o=1, minstret=1.
- JAL id=0x1, dst=1, data=0x200, payload=0x104, is_jump=1, taken=1, predicted=0 -> rf writes x1=0x104, redirect_o=1, redirect_pc_o=0x200, epoch_o=1, mispredict_cnt=1.
- After the previous case, inputs id=0x2 and id=0x3 (epoch 0) arrive -> no rf_we_o, no retire_o; then id=0x8 (epoch 1, seq 0) -> accepted, seq_err_o=0.
- Not-taken branch, predicted taken, payload=0x44 -> redirect_pc_o=0x44; correctly predicted branch -> no redirect.
- Write to dst=0 with data=0xFFFF -> rf_we_o=0, retire_o=1; ids 0,1,3 in sequence -> seq_err_o=1 after id 3 and stays set.
- Assert rst low mid-stream while wb_write_i=1 -> all outputs 0 immediately (asynchronously), epoch=0, counters cleared.
